// File: rtl/pi_spi_master.sv
// ---------------------------------------------------------------------------
// pi_spi_master
//   SPI mode-0 initiator for the 4-byte command frame the FPGA-side SPI
//   responder decodes: {rw_b, 6'b0, addr[16]}, addr[15:8], addr[7:0], data,
//   sent MSB first. A read appends a fifth byte (MOSI = 0) during which MISO
//   is shifted into rd_data. Stands in for the Raspberry Pi host on the bench
//   and during bring-up.
//
//   Everything runs on clk. spi_sclk is a registered divider output and is
//   never used as a clock here.
//
// Parameters
//   CLK_DIV   spi_sclk half-period in clk cycles (2..255)
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      transaction request, accepted when idle
//   rw_b       1 = read, 0 = write (latched at accept)
//   addr       17-bit target address (latched at accept)
//   wr_data    write data byte (latched at accept, ignored for reads)
//   busy       high from the accept edge through the inter-frame gap
//   done       one-cycle pulse on the edge spi_cs_n deasserts
//   rd_data    byte received in frame byte 4 of the last read
//   spi_sclk   SPI clock, idles low
//   spi_cs_n   chip select, active low
//   spi_mosi   master out
//   spi_miso   master in
// ---------------------------------------------------------------------------
module pi_spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rw_b,
   input  logic [16:0] addr,
   input  logic [7:0]  wr_data,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rd_data,
   output logic        spi_sclk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [7:0] HP_LAST      = 8'(CLK_DIV - 1);
   localparam logic [5:0] LAST_BIT_WR  = 6'd31;
   localparam logic [5:0] LAST_BIT_RD  = 6'd39;
   localparam logic [5:0] FIRST_RD_BIT = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_SCLK_LO = 3'd2,
      ST_SCLK_HI = 3'd3,
      ST_HOLD    = 3'd4,
      ST_GAP     = 3'd5
   } state_t;

   // Frame is built left-aligned in 40 bits; a write only shifts out the
   // top 32, a read shifts all 40 (last byte is zero).
   function automatic logic [39:0] build_frame(
      input logic        rw,
      input logic [16:0] a,
      input logic [7:0]  d
   );
      logic [7:0] data_byte;
      data_byte = rw ? 8'h00 : d;
      return {rw, 6'b000000, a[16], a[15:8], a[7:0], data_byte, 8'h00};
   endfunction

   state_t      state_r;
   logic [7:0]  hp_cnt_r;
   logic [5:0]  bit_cnt_r;
   logic [5:0]  last_bit_r;
   logic        is_read_r;
   logic [38:0] tx_sr_r;
   logic [7:0]  rx_sr_r;
   logic        busy_r;
   logic        done_r;
   logic [7:0]  rd_data_r;
   logic        sclk_r;
   logic        cs_n_r;
   logic        mosi_r;

   logic [39:0] frame_s;
   logic        hp_end_s;
   logic        accept_s;

   // Frame assembly, half-period terminal count and accept decode.
   always_comb begin
      frame_s  = build_frame(rw_b, addr, wr_data);
      hp_end_s = (hp_cnt_r == HP_LAST);
      // The last edge of the gap doubles as an accept edge so that a start
      // held high yields frames separated by exactly one gap.
      if (state_r == ST_IDLE) begin
         accept_s = start;
      end else if ((state_r == ST_GAP) && hp_end_s) begin
         accept_s = start;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Frame sequencer: owns all counters, shift registers and SPI outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         hp_cnt_r   <= 8'd0;
         bit_cnt_r  <= 6'd0;
         last_bit_r <= LAST_BIT_WR;
         is_read_r  <= 1'b0;
         tx_sr_r    <= 39'd0;
         rx_sr_r    <= 8'h00;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rd_data_r  <= 8'h00;
         sclk_r     <= 1'b0;
         cs_n_r     <= 1'b1;
         mosi_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept_s) begin
            // All inputs are captured here; later changes are ignored.
            state_r    <= ST_SETUP;
            hp_cnt_r   <= 8'd0;
            bit_cnt_r  <= 6'd0;
            last_bit_r <= rw_b ? LAST_BIT_RD : LAST_BIT_WR;
            is_read_r  <= rw_b;
            tx_sr_r    <= frame_s[38:0];
            rx_sr_r    <= 8'h00;
            busy_r     <= 1'b1;
            cs_n_r     <= 1'b0;
            mosi_r     <= frame_s[39];
         end else begin
            case (state_r)
               ST_IDLE: begin
                  hp_cnt_r <= 8'd0;
               end
               ST_SETUP, ST_SCLK_LO: begin
                  if (hp_end_s) begin
                     hp_cnt_r <= 8'd0;
                     sclk_r   <= 1'b1;
                     state_r  <= ST_SCLK_HI;
                  end else begin
                     hp_cnt_r <= hp_cnt_r + 8'd1;
                  end
               end
               ST_SCLK_HI: begin
                  if (hp_end_s) begin
                     hp_cnt_r <= 8'd0;
                     sclk_r   <= 1'b0;
                     // Responder changes MISO on the falling sclk edge, so
                     // the value is still stable on the edge that drives
                     // sclk low.
                     if (is_read_r && (bit_cnt_r >= FIRST_RD_BIT)) begin
                        rx_sr_r <= {rx_sr_r[6:0], spi_miso};
                     end else begin
                        rx_sr_r <= rx_sr_r;
                     end
                     if (bit_cnt_r == last_bit_r) begin
                        mosi_r  <= 1'b0;
                        state_r <= ST_HOLD;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        mosi_r    <= tx_sr_r[38];
                        tx_sr_r   <= {tx_sr_r[37:0], 1'b0};
                        state_r   <= ST_SCLK_LO;
                     end
                  end else begin
                     hp_cnt_r <= hp_cnt_r + 8'd1;
                  end
               end
               ST_HOLD: begin
                  if (hp_end_s) begin
                     hp_cnt_r <= 8'd0;
                     cs_n_r   <= 1'b1;
                     done_r   <= 1'b1;
                     if (is_read_r) begin
                        rd_data_r <= rx_sr_r;
                     end else begin
                        rd_data_r <= rd_data_r;
                     end
                     state_r <= ST_GAP;
                  end else begin
                     hp_cnt_r <= hp_cnt_r + 8'd1;
                  end
               end
               ST_GAP: begin
                  if (hp_end_s) begin
                     hp_cnt_r <= 8'd0;
                     busy_r   <= 1'b0;
                     state_r  <= ST_IDLE;
                  end else begin
                     hp_cnt_r <= hp_cnt_r + 8'd1;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  hp_cnt_r  <= 8'd0;
                  bit_cnt_r <= 6'd0;
                  busy_r    <= 1'b0;
                  sclk_r    <= 1'b0;
                  cs_n_r    <= 1'b1;
                  mosi_r    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign rd_data  = rd_data_r;
   assign spi_sclk = sclk_r;
   assign spi_cs_n = cs_n_r;
   assign spi_mosi = mosi_r;

endmodule
